matrix_inv2x2_hs: RTL and testbench
===================================

# matrix_inv2x2_hs

- Parametrised, handshaked successor to the fixed Q2.14 2x2 matrix inverter.
- Accepts one signed fixed-point 2x2 matrix [a b; c d] over a valid/ready interface and returns its inverse [d −b; −c a]/det over a second valid/ready interface.
- Width and fraction are set by parameters. The reciprocal is formed by a bit-serial divider, so the block is small and multi-cycle.
- Flags singular matrices (error) and saturated results (ovf). Sits between the coefficient source and downstream filter/solver stages.

## Interface

- W, 16, element width (signed, two's complement)
- F, 14, fraction bits of every element (QW−F.F)
- RF, 16, fraction bits of the reciprocal
- QW, 2*F+RF+1, derived: divider quotient width and iteration count; not overridden

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  a, b, c, d are valid
- in_ready  out  1  block can accept a matrix
- a, b, c, d  in  W each  signed input elements, QW−F.F
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- a_inv, b_inv, c_inv, d_inv  out  W each  signed inverse elements, QW−F.F
- error  out  1  det == 0; qualified by out_valid
- ovf  out  1  at least one output saturated; qualified by out_valid

## Operation

- States: IDLE, DET, DIV, MUL, OUT.
- in_ready = (state == IDLE).
- IDLE:
  - Accept on in_valid & in_ready and register a, b, c, d.
  - Go to DET.
- DET:
  - det_raw = a*d − b*c, exact, 2W+1 bits signed, 2F fraction bits.
  - Register sign(det_raw) and |det_raw|.
  - det_raw == 0: set error, zero all four outputs, clear ovf, go to OUT.
  - Otherwise go to DIV.
- DIV:
  - Restoring unsigned division, one quotient bit per cycle, MSB first, QW cycles.
  - R = floor(2^(2F+RF) / |det_raw|).
  - R is the magnitude of 1/det with RF fraction bits.
- MUL, all four results computed in one cycle:
  - Magnitude: m = (|e| * R) >> RF, truncated. e is d for a_inv, b for b_inv, c for c_inv, a for d_inv.
  - Sign: result sign = sign(e) XOR sign(det), then XOR 1 for b_inv and c_inv. Apply the sign to the magnitude, so rounding is toward zero.
  - Saturate to [−2^(W−1), 2^(W−1)−1]. ovf = OR of the four saturation events.
  - error = 0. Go to OUT.
- OUT:
  - out_valid = 1. Outputs, error and ovf are held stable until out_ready.
  - On out_valid & out_ready, go to IDLE.
  - No accept in the same cycle, because in_ready is low in OUT.
- Reset, taking effect at the next clock edge from any state:
  - state = IDLE, out_valid = 0, all inverse outputs = 0, error = 0, ovf = 0, divider registers cleared.
  - Any in-flight matrix is discarded. in_ready = 1 in the first cycle after reset.
- in_valid while busy is ignored; the source must hold it until in_ready.
- Input changes after accept have no effect.

## Timing

- Accept edge = cycle 0.
- Non-singular: out_valid is high from cycle QW+3 (DET at cycle 1, DIV cycles 2..QW+1, MUL cycle QW+2). Defaults: QW = 45, out_valid at cycle 48.
- Singular: out_valid is high from cycle 2.
- Next accept is possible at the earliest one cycle after the out handshake. Peak throughput is one matrix per QW+4 cycles when out_ready is held high.
- All outputs are registered; no combinational path from in_* to out_*.

## Test plan

- Identity, defaults: a = d = 0x4000, b = c = 0.
  - Expect R = 65536.
  - Expect a_inv = d_inv = 0x4000, b_inv = c_inv = 0x0000, error = 0, ovf = 0.
  - out_valid at cycle 48.
- General: a = d = 0x4000, b = c = 0x2000 (det = 0.75).
  - Expect det_raw = 201326592, R = 87381.
  - Expect a_inv = d_inv = 0x5555, b_inv = c_inv = 0xD556, ovf = 0.
- Negative det: a = d = 0, b = c = 0x4000 (det = −1.0).
  - Expect a_inv = d_inv = 0, b_inv = c_inv = 0x4000, error = 0.
- Singular and saturation:
  - a = 0x4000, b = 0x2000, c = 0x4000, d = 0x2000: expect error = 1, all outputs 0, out_valid at cycle 2.
  - a = d = 0x2000, b = c = 0: expect a_inv = d_inv = 0x7FFF, ovf = 1.
- Backpressure: out_ready = 0 for 10 cycles after out_valid.
  - Outputs and flags stay stable; in_ready stays 0.
  - A new in_valid pulse during this window is not accepted.
  - After out_ready, in_ready rises the next cycle.
- Reset mid-DIV: assert reset at cycle 20 of a non-singular job.
  - Next cycle: out_valid = 0, outputs = 0, in_ready = 1.
  - A following identity matrix yields the correct result at cycle 48 after its accept.

Source files
------------

// File: rtl/matrix_inv2x2_hs.sv
// matrix_inv2x2_hs: handshaked signed fixed-point 2x2 matrix inverter.
// inv([a b; c d]) = [d -b; -c a] / det. A restoring bit-serial divider
// forms the reciprocal of |det|, and four multiplies scale the elements.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid is high only in OUT,
// and the results stay stable there until out_ready is seen.
module matrix_inv2x2_hs #(
    parameter int W  = 16,
    parameter int F  = 14,
    parameter int RF = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a_inv,
    output logic [W-1:0] b_inv,
    output logic [W-1:0] c_inv,
    output logic [W-1:0] d_inv,
    output logic         error,
    output logic         ovf
);
    localparam int QW = 2*F + RF + 1;   // quotient width = iteration count
    localparam int DW = 2*W + 1;        // exact determinant width
    localparam int CW = $clog2(QW);

    typedef enum logic [2:0] {S_IDLE, S_DET, S_DIV, S_MUL, S_OUT} state_t;
    state_t state, state_next;

    logic signed [W-1:0]   a_r, b_r, c_r, d_r;
    logic signed [2*W-1:0] p_ad, p_bc;
    logic signed [DW-1:0]  det_raw;
    logic [DW-1:0]         det_mag_w;
    logic                  det_neg;
    logic [DW-1:0]         det_abs;
    logic [DW-1:0]         rem_r;
    logic [QW-1:0]         quo_r;
    logic [CW-1:0]         cnt;
    logic [DW:0]           rem_sh;
    logic [DW-1:0]         rem_sub;
    logic                  rem_ge;
    logic [W:0]            res_a, res_b, res_c, res_d;

    // Scale one element by the reciprocal, apply sign, saturate.
    // Returns {saturated, value}. Truncating the magnitude before the sign
    // is applied gives rounding toward zero.
    function automatic logic [W:0] scale(input logic [W-1:0] e,
                                         input logic [QW-1:0] r,
                                         input logic neg);
        logic [W-1:0]    mag_e;
        logic [W+QW-1:0] prod;
        logic [QW-1:0]   m;
        logic            hi_nz;
        logic            sat;
        logic [W-1:0]    val;
        mag_e = e[W-1] ? (~e + 1'b1) : e;
        prod  = (W+QW)'(mag_e) * (W+QW)'(r);
        m     = QW'(prod >> RF);
        hi_nz = |m[QW-1:W];
        if (!neg) begin
            sat = hi_nz | m[W-1];
            val = sat ? {1'b0, {(W-1){1'b1}}} : m[W-1:0];
        end else begin
            sat = hi_nz | (m[W-1] & (|m[W-2:0]));
            val = sat ? {1'b1, {(W-1){1'b0}}} : (~m[W-1:0] + 1'b1);
        end
        return {sat, val};
    endfunction

    // Exact determinant of the captured matrix and its magnitude.
    assign p_ad      = (2*W)'(a_r) * (2*W)'(d_r);
    assign p_bc      = (2*W)'(b_r) * (2*W)'(c_r);
    assign det_raw   = DW'(p_ad) - DW'(p_bc);
    assign det_mag_w = det_raw[DW-1] ? (~det_raw + 1'b1) : det_raw;

    // One restoring-division step; the dividend 2^(QW-1) has only its MSB set.
    assign rem_sh  = {rem_r, (cnt == '0)};
    assign rem_ge  = (rem_sh >= {1'b0, det_abs});
    assign rem_sub = rem_sh[DW-1:0] - det_abs;

    // Element scaling: a_inv from d, b_inv from -b, c_inv from -c, d_inv from a.
    assign res_a = scale(d_r, quo_r, d_r[W-1] ^ det_neg);
    assign res_b = scale(b_r, quo_r, b_r[W-1] ^ det_neg ^ 1'b1);
    assign res_c = scale(c_r, quo_r, c_r[W-1] ^ det_neg ^ 1'b1);
    assign res_d = scale(a_r, quo_r, a_r[W-1] ^ det_neg);

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)                  state_next = S_DET;
            S_DET:  state_next = (det_raw == '0) ? S_OUT : S_DIV;
            S_DIV:  if (cnt == CW'(QW-1))          state_next = S_MUL;
            S_MUL:  state_next = S_OUT;
            S_OUT:  if (out_ready)                 state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: capture, determinant, division steps and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0;
            det_neg <= 1'b0; det_abs <= '0;
            rem_r <= '0; quo_r <= '0; cnt <= '0;
            a_inv <= '0; b_inv <= '0; c_inv <= '0; d_inv <= '0;
            error <= 1'b0; ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r <= a; b_r <= b; c_r <= c; d_r <= d;
                    end
                end
                S_DET: begin
                    det_neg <= det_raw[DW-1];
                    det_abs <= det_mag_w;
                    rem_r   <= '0;
                    quo_r   <= '0;
                    cnt     <= '0;
                    if (det_raw == '0) begin
                        a_inv <= '0; b_inv <= '0; c_inv <= '0; d_inv <= '0;
                        error <= 1'b1;
                        ovf   <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem_r <= rem_ge ? rem_sub : rem_sh[DW-1:0];
                    quo_r <= {quo_r[QW-2:0], rem_ge};
                    cnt   <= cnt + 1'b1;
                end
                S_MUL: begin
                    a_inv <= res_a[W-1:0];
                    b_inv <= res_b[W-1:0];
                    c_inv <= res_c[W-1:0];
                    d_inv <= res_d[W-1:0];
                    ovf   <= res_a[W] | res_b[W] | res_c[W] | res_d[W];
                    error <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_inv2x2_hs.sv
// Bench for matrix_inv2x2_hs: directed cases with literal results and
// latencies, backpressure, reset during division, and random matrices
// scored against an arithmetic model of the inverse.
module tb_matrix_inv2x2_hs;
  localparam int W  = 16;
  localparam int F  = 14;
  localparam int RF = 16;
  localparam int QW = 2*F + RF + 1;
  localparam int VW = 4*W + 2;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_inv, b_inv, c_inv, d_inv;
  logic         error;
  logic         ovf;
  logic [VW-1:0] dut_vec;

  int total;
  int bad;
  logic [VW-1:0] exp_q[$];

  matrix_inv2x2_hs #(.W(W), .F(F), .RF(RF)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_inv(a_inv), .b_inv(b_inv), .c_inv(c_inv), .d_inv(d_inv),
    .error(error), .ovf(ovf)
  );

  assign dut_vec = {a_inv, b_inv, c_inv, d_inv, error, ovf};

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inverse from plain integer arithmetic: {a_inv, b_inv, c_inv, d_inv, error, ovf}.
  function automatic logic [VW-1:0] model(input logic [W-1:0] xa, xb, xc, xd);
    longint sa, sb, sc, sd, det, r, mag, v;
    longint e[4];
    int flip[4];
    logic [W-1:0] res[4];
    logic o;
    sa = longint'($signed(xa)); sb = longint'($signed(xb));
    sc = longint'($signed(xc)); sd = longint'($signed(xd));
    det = sa*sd - sb*sc;
    if (det == 0) return {{(4*W){1'b0}}, 2'b10};
    r = (longint'(1) << (2*F + RF)) / (det < 0 ? -det : det);
    e[0] = sd; e[1] = sb; e[2] = sc; e[3] = sa;
    flip[0] = 0; flip[1] = 1; flip[2] = 1; flip[3] = 0;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mag = ((e[i] < 0 ? -e[i] : e[i]) * r) >> RF;
      v = (((e[i] < 0) ^ (det < 0) ^ (flip[i] != 0)) != 0) ? -mag : mag;
      if (v > 32767) begin v = 32767; o = 1'b1; end
      if (v < -32768) begin v = -32768; o = 1'b1; end
      res[i] = v[W-1:0];
    end
    return {res[0], res[1], res[2], res[3], 1'b0, o};
  endfunction

  // scoreboard: every cycle out_valid is high, outputs must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=%0h required=none", dut_vec);
      end else begin
        check("out_vec", dut_vec, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: called at posedge+1; returns at accept edge+1
  task automatic send(input logic [W-1:0] xa, xb, xc, xd);
    int n;
    n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    a = xa; b = xb; c = xc; d = xd;
    in_valid = 1'b1;
    exp_q.push_back(model(xa, xb, xc, xd));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
  endtask

  // counts negedges after accept until out_valid (first negedge = 1)
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic run_dir(input string name, input logic [W-1:0] xa, xb, xc, xd,
                         input int lat, input logic [VW-1:0] ev);
    int cyc;
    send(xa, xb, xc, xd);
    wait_valid(cyc);
    check({name, "_lat"}, cyc, lat);
    check({name, "_val"}, dut_vec, ev);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_elem();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 65535));
      1: return W'($urandom_range(0, 16384)) ^ ($urandom_range(0, 1) != 0 ? 16'hFFFF : 16'h0000);
      2: case ($urandom_range(0, 4))
           0: return 16'h8000;
           1: return 16'h7FFF;
           2: return 16'h0000;
           3: return 16'h4000;
           default: return 16'hC000;
         endcase
      default: return W'($urandom_range(0, 8192));
    endcase
  endfunction

  initial begin
    int cyc;
    int n;
    logic [W-1:0] ra, rb, rc, rd;
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", dut_vec, '0);
    @(posedge clk); #1;

    // model pinned by hand-computed values
    check("model_identity", model(16'h4000, 16'h0000, 16'h0000, 16'h4000), {16'h4000, 16'h0000, 16'h0000, 16'h4000, 2'b00});
    check("model_general", model(16'h4000, 16'h2000, 16'h2000, 16'h4000), {16'h5555, 16'hD556, 16'hD556, 16'h5555, 2'b00});
    check("model_singular", model(16'h4000, 16'h2000, 16'h4000, 16'h2000), {64'h0, 2'b10});
    check("model_sat", model(16'h2000, 16'h0000, 16'h0000, 16'h2000), {16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 2'b01});

    // directed cases
    run_dir("identity", 16'h4000, 16'h0000, 16'h0000, 16'h4000, QW+3, {16'h4000, 16'h0000, 16'h0000, 16'h4000, 2'b00});
    run_dir("general", 16'h4000, 16'h2000, 16'h2000, 16'h4000, QW+3, {16'h5555, 16'hD556, 16'hD556, 16'h5555, 2'b00});
    run_dir("neg_det", 16'h0000, 16'h4000, 16'h4000, 16'h0000, QW+3, {16'h0000, 16'h4000, 16'h4000, 16'h0000, 2'b00});
    run_dir("singular", 16'h4000, 16'h2000, 16'h4000, 16'h2000, 2, {64'h0, 2'b10});
    run_dir("saturate", 16'h2000, 16'h0000, 16'h0000, 16'h2000, QW+3, {16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 2'b01});

    // backpressure: hold out_ready low for 10 cycles, pulse a new matrix meanwhile
    out_ready = 1'b0;
    send(16'h4000, 16'h2000, 16'h2000, 16'h4000);
    wait_valid(cyc);
    check("bp_lat", cyc, QW+3);
    @(posedge clk); #1;
    a = 16'h4000; b = 16'h0000; c = 16'h0000; d = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid_held", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_rise", in_ready, 1'b1);
    check("bp_out_valid_drop", out_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_pulse_ignored", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // leave non-zero outputs behind, then reset in the middle of division
    run_dir("saturate2", 16'h2000, 16'h0000, 16'h0000, 16'h2000, QW+3, {16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 2'b01});
    send(16'h4000, 16'h2000, 16'h2000, 16'h4000);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("middiv_out_valid", out_valid, 1'b0);
    check("middiv_outputs", dut_vec, '0);
    check("middiv_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    run_dir("post_reset_identity", 16'h4000, 16'h0000, 16'h0000, 16'h4000, QW+3, {16'h4000, 16'h0000, 16'h0000, 16'h4000, 2'b00});

    // random matrices with random backpressure
    for (int k = 0; k < 40; k++) begin
      ra = rnd_elem(); rb = rnd_elem(); rc = rnd_elem(); rd = rnd_elem();
      if ($urandom_range(0, 7) == 0) begin rc = ra; rd = rb; end
      out_ready = ($urandom_range(0, 3) != 0);
      send(ra, rb, rc, rd);
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        n++;
      end
      check("rand_drain", exp_q.size(), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
